vmx_acc_drain: RTL
==================

Name: vmx_acc_drain

Overview:
- Downstream drain stage for the vmx systolic PE column.
- Consumes the 32-bit sum_out stream leaving the last PE and accumulates tile_num consecutive partial sums into one wide result per output vector element, honouring SIMD lane packing.
- Buffers finished results in a small FIFO and presents them on a valid/ready interface to the writeback/DMA side.
- The PE chain has no backpressure, so input loss is detected and flagged rather than stalled.

Parameters:
- FIFO_DEPTH, 4, result FIFO entries (power of 2, >=2)
- CNT_W, 8, width of the tile_num and vec_len counters

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start  in  1  one-cycle pulse; latches simd_mode, tile_num and vec_len when in IDLE
- simd_mode  in  1  0 = 8-bit mode (two packed lanes), 1 = 16-bit mode (one lane)
- tile_num  in  CNT_W  partial sums per result; 0 is treated as 1
- vec_len  in  CNT_W  results per run; 0 is treated as 1
- sum_valid  in  1  sum_in carries a valid partial sum this cycle
- sum_in  in  32  partial sum from the last PE's sum_out
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data
- out_data  out  48  FIFO head result
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle pulse when the last result of a run is pushed
- overflow  out  1  sticky; a sum_valid sample was dropped

Behaviour:
- Reset is asynchronous and active-low; there is one clock domain. All registers clear on reset: out_valid=0, out_data=0, busy=0, done=0, overflow=0, FIFO empty, FSM=IDLE, counters=0.
- Reset asserted mid-run aborts the run. FIFO contents are lost.
- Arithmetic is two's complement, signed. Mode is latched at start and held for the whole run.
  - Mode 1: acc[47:0] accumulates sign-extended sum_in[31:0].
  - Mode 0: lane0 acc[23:0] accumulates sign-extended sum_in[15:0]; lane1 acc[47:24] accumulates sign-extended sum_in[31:16]. There is no carry between lanes, and each lane wraps modulo 2^24.
  - Mode 1 wraps modulo 2^48. No saturation in either mode.
- FSM states are IDLE, ACC and HOLD.
- IDLE:
  - start=1: latch parameters, set tile_cnt=0 and vec_cnt=0, go to ACC.
  - sum_valid in IDLE is ignored and does not set overflow.
  - start outside IDLE is ignored.
- ACC, on each sum_valid:
  - tile_cnt==0: acc loads the extended sample (no clear cycle needed).
  - Otherwise: acc = acc + the extended sample.
  - Cycles without sum_valid hold all state.
- Last sample (tile_cnt==tile_num_eff-1): the completed sum (acc plus the current sample) is the result.
  - If the FIFO is not full, or a pop occurs in the same cycle, push the result that cycle, set tile_cnt=0 and increment vec_cnt.
  - Otherwise store the result in a hold register and go to HOLD.
- HOLD:
  - Push the hold register on the first cycle the FIFO has space, then advance vec_cnt as above.
  - Any sum_valid while in HOLD is dropped and sets overflow; the accumulator is unaffected.
- End of run: after the push for vec_cnt==vec_len_eff-1, pulse done for exactly 1 cycle (the push cycle) and go to IDLE. busy falls the cycle after.
- Latency: the result enters the FIFO on the clock edge that samples the last sum_valid. out_valid rises the following cycle; the FIFO is registered.
- FIFO:
  - A pop occurs when out_valid && out_ready. out_data holds its value while out_valid=1 && out_ready=0.
  - Simultaneous push and pop when full is permitted and the count is unchanged.
  - Push and pop on empty: the push lands and out_valid=1 next cycle (no fall-through).
  - Pointers wrap modulo FIFO_DEPTH.
  - When empty, out_data holds its last value and out_valid=0.
- overflow clears only on reset. It is not cleared by start.

Test Plan:
- Mode 1, tile_num=3, vec_len=1; sum_in = 0x00000005, 0xFFFFFFFE, 0x00000010 on consecutive cycles; out_ready=1 -> a single result 0x000000000013, out_valid high for 1 cycle, done pulses on the 3rd sample edge.
- Mode 0, tile_num=2; samples 0x7FFF8000 then 0x00018000 -> lane1=0x008000, lane0=0xFF0000; out_data=0x008000FF0000 with no cross-lane carry.
- tile_num=0, vec_len=4, out_ready=1; samples 1,2,3,4 -> four results equal to the samples in order; done on the 4th.
- FIFO_DEPTH=4, out_ready=0, tile_num=1, vec_len=6; six samples -> FIFO full after 4, 5th result in HOLD, 6th sample dropped and overflow=1. Raise out_ready -> 5 results drain in order.
- Full FIFO with a push on the same cycle as a pop -> count stays 4, order preserved, no overflow.
- Assert rst_n low mid-ACC with the FIFO holding 2 entries -> out_valid=0, busy=0, overflow=0 immediately. A subsequent start runs normally.

Source files
------------

// File: rtl/vmx_acc_drain.sv
// vmx_acc_drain: accumulates tile_num partial sums per element from the PE
// column, buffers results in a FIFO, and drives them out on a valid/ready port.
//
// Ports:
//   clk, rst_n               - clock and asynchronous active-low reset
//   start                    - latches simd_mode/tile_num/vec_len when idle
//   simd_mode                - 0: two 24-bit lanes, 1: one 48-bit lane
//   tile_num, vec_len        - partial sums per result, results per run (0 -> 1)
//   sum_valid, sum_in        - partial-sum stream from the last PE
//   out_valid/out_ready      - result handshake; out_data is the FIFO head
//   busy, done, overflow     - run status; overflow is sticky until reset
module vmx_acc_drain #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             simd_mode,
  input  logic [CNT_W-1:0] tile_num,
  input  logic [CNT_W-1:0] vec_len,
  input  logic             sum_valid,
  input  logic [31:0]      sum_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [47:0]      out_data,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_t;

  state_t           state;
  logic             mode_q;
  logic [CNT_W-1:0] tile_num_q;
  logic [CNT_W-1:0] vec_len_q;
  logic [CNT_W-1:0] tile_cnt;
  logic [CNT_W-1:0] vec_cnt;
  logic [47:0]      acc;
  logic [47:0]      hold_q;

  logic [47:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic [47:0]      ext;
  logic [47:0]      sum_nxt;
  logic             last_tile;
  logic             last_vec;
  logic             pop;
  logic             room;
  logic             push;
  logic [47:0]      push_data;
  logic [CW-1:0]    lvl;

  assign out_valid = (count != '0);
  assign busy      = (state != IDLE);
  assign pop       = out_valid && out_ready;
  assign room      = (count != FULL_CNT) || pop;
  assign last_tile = (tile_cnt == tile_num_q - CNT_W'(1));
  assign last_vec  = (vec_cnt == vec_len_q - CNT_W'(1));
  assign lvl       = count - CW'(pop);

  // Sign-extend the sample per lane; in 8-bit mode the lanes never carry
  // into each other, so each 24-bit half is added separately.
  always_comb begin
    if (mode_q)
      ext = {{16{sum_in[31]}}, sum_in};
    else
      ext = {{8{sum_in[31]}}, sum_in[31:16],
             {8{sum_in[15]}}, sum_in[15:0]};
    if (tile_cnt == '0)
      sum_nxt = ext;
    else if (mode_q)
      sum_nxt = acc + ext;
    else
      sum_nxt = {acc[47:24] + ext[47:24],
                 acc[23:0] + ext[23:0]};
  end

  always_comb begin
    push      = 1'b0;
    push_data = sum_nxt;
    unique case (state)
      ACC: begin
        if (sum_valid && last_tile && room)
          push = 1'b1;
      end
      HOLD: begin
        if (room) begin
          push      = 1'b1;
          push_data = hold_q;
        end
      end
      default: ;
    endcase
  end

  // FIFO. out_data is a register so it keeps its last value once empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_data <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push) - CW'(pop);
      if (lvl != '0)
        out_data <= mem[rd_ptr + PW'(pop)];
      else if (push)
        out_data <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode_q     <= 1'b0;
      tile_num_q <= '0;
      vec_len_q  <= '0;
      tile_cnt   <= '0;
      vec_cnt    <= '0;
      acc        <= '0;
      hold_q     <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mode_q     <= simd_mode;
            tile_num_q <= (tile_num == '0) ? CNT_W'(1) : tile_num;
            vec_len_q  <= (vec_len == '0) ? CNT_W'(1) : vec_len;
            tile_cnt   <= '0;
            vec_cnt    <= '0;
            state      <= ACC;
          end
        end
        ACC: begin
          if (sum_valid) begin
            if (last_tile) begin
              if (room) begin
                tile_cnt <= '0;
                if (last_vec) begin
                  done  <= 1'b1;
                  state <= IDLE;
                end else begin
                  vec_cnt <= vec_cnt + CNT_W'(1);
                end
              end else begin
                hold_q <= sum_nxt;
                state  <= HOLD;
              end
            end else begin
              acc      <= sum_nxt;
              tile_cnt <= tile_cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          // No backpressure upstream: samples arriving here are lost.
          if (sum_valid)
            overflow <= 1'b1;
          if (room) begin
            tile_cnt <= '0;
            if (last_vec) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              vec_cnt <= vec_cnt + CNT_W'(1);
              state   <= ACC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
